// File: rtl/n64_pkg.sv
// Shared N64 controller definitions: command bytes, scheduler state encoding
// and requester indices.
package n64_pkg;

   localparam logic [7:0] CMD_INFO  = 8'h00;
   localparam logic [7:0] CMD_POLL  = 8'h01;
   localparam logic [7:0] CMD_RESET = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } sched_state_e;

   // Requester indices, lowest index wins arbitration
   localparam int unsigned REQ_RESET = 0;
   localparam int unsigned REQ_INFO  = 1;
   localparam int unsigned REQ_POLL  = 2;
   localparam int unsigned NUM_REQ   = 3;

endpackage

// File: rtl/n64_poll_tick.sv
// Free-running period counter; tick_c is high for one cycle every PERIOD cycles.
module n64_poll_tick #(
   parameter int unsigned PERIOD = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick_c
);

   localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CNT_W-1:0] cnt;

   assign tick_c = (cnt == CNT_W'(PERIOD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         cnt <= '0;
      else if (tick_c) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/n64_poll_scheduler.sv
// Arbitrates reset/info/poll requests onto the N64 transaction engine with
// timeout, bounded retry and inter-transaction gap. N64_SCHED_CHANGE_ONLY_EN
// makes button_valid pulse only when the polled data changes.
module n64_poll_scheduler #(
   parameter int unsigned POLL_PERIOD    = 100000,
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter int unsigned MAX_RETRIES    = 2,
   parameter int unsigned GAP_CYCLES     = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        poll_enable,
   input  logic        reset_req,
   input  logic        info_req,
   output logic        cmd_start,
   output logic [7:0]  cmd_byte,
   input  logic        engine_active,
   input  logic        rx_done,
   input  logic        rx_error,
   input  logic [31:0] rx_data,
   output logic [31:0] button_data,
   output logic        button_valid,
   output logic [23:0] status_data,
   output logic        status_valid,
   output logic [7:0]  err_count,
   output logic        busy
);

   import n64_pkg::*;

   localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam int unsigned RETRY_W = 3;

   sched_state_e       state, state_d;
   logic [NUM_REQ-1:0] pend, pend_d, grant;
   logic [7:0]         grant_cmd;
   logic               grant_ok, tick, reset_req_q, reset_rise;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retry_cnt;
   logic               retry_pend, cur_poll;
   logic               rx_ok, rx_fail, gap_done, btn_pulse;
   logic               cmd_start_d, busy_d;

   n64_poll_tick #(.PERIOD(POLL_PERIOD)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_c (tick)
   );

   assign reset_rise = reset_req & ~reset_req_q;
   assign grant_ok   = (state == ST_IDLE) && (|pend) && !engine_active;
   assign rx_ok      = (state == ST_WAIT) && rx_done && !rx_error;
   assign rx_fail    = (state == ST_WAIT) &&
                       ((rx_done && rx_error) || (!rx_done && cnt == CNT_W'(TIMEOUT_CYCLES - 1)));
   assign gap_done   = (state == ST_GAP) && (cnt == CNT_W'(GAP_CYCLES - 1));

   // Fixed priority: reset > info > poll
   always_comb begin
      grant     = '0;
      grant_cmd = CMD_POLL;
      if (pend[REQ_RESET]) begin
         grant[REQ_RESET] = grant_ok;
         grant_cmd        = CMD_RESET;
      end else if (pend[REQ_INFO]) begin
         grant[REQ_INFO] = grant_ok;
         grant_cmd       = CMD_INFO;
      end else if (pend[REQ_POLL]) begin
         grant[REQ_POLL] = grant_ok;
         grant_cmd       = CMD_POLL;
      end
   end

   // New requests override a same-cycle grant clear; disabled polling drops a waiting poll
   always_comb begin
      pend_d = pend & ~grant;
      if (reset_rise)   pend_d[REQ_RESET] = 1'b1;
      if (info_req)     pend_d[REQ_INFO]  = 1'b1;
      if (tick)         pend_d[REQ_POLL]  = 1'b1;
      if (!poll_enable) pend_d[REQ_POLL]  = 1'b0;
   end

`ifdef N64_SCHED_CHANGE_ONLY_EN
   logic have_button;

   assign btn_pulse = !have_button || (rx_data != button_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  have_button <= 1'b0;
      else if (rx_ok && cur_poll) have_button <= 1'b1;
   end
`else
   assign btn_pulse = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:  if (grant_ok) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (rx_ok || rx_fail) state_d = ST_GAP;
         ST_GAP:   if (gap_done) state_d = retry_pend ? ST_ISSUE : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_start_d = 1'b0;
      busy_d      = 1'b0;
      if (state_d == ST_ISSUE) cmd_start_d = 1'b1;
      if (state_d != ST_IDLE)  busy_d      = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reset_req_q  <= 1'b0;
         pend         <= '0;
         cnt          <= '0;
         retry_cnt    <= '0;
         retry_pend   <= 1'b0;
         cur_poll     <= 1'b0;
         cmd_start    <= 1'b0;
         cmd_byte     <= '0;
         busy         <= 1'b0;
         button_data  <= '0;
         button_valid <= 1'b0;
         status_data  <= '0;
         status_valid <= 1'b0;
         err_count    <= '0;
      end else begin
         reset_req_q  <= reset_req;
         pend         <= pend_d;
         cmd_start    <= cmd_start_d;
         busy         <= busy_d;
         button_valid <= 1'b0;
         status_valid <= 1'b0;

         // One counter serves both the WAIT timeout and the GAP length
         if (state_d != state)      cnt <= '0;
         else if (state != ST_IDLE) cnt <= cnt + CNT_W'(1);

         if (grant_ok) begin
            cmd_byte   <= grant_cmd;
            cur_poll   <= grant[REQ_POLL];
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
         end

         if (rx_ok) begin
            retry_pend <= 1'b0;
            if (cur_poll) begin
               button_data  <= rx_data;
               button_valid <= btn_pulse;
            end else begin
               status_data  <= rx_data[23:0];
               status_valid <= 1'b1;
            end
         end

         if (rx_fail) begin
            if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
               retry_cnt  <= retry_cnt + RETRY_W'(1);
               retry_pend <= 1'b1;
            end else begin
               retry_pend <= 1'b0;
               if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Scoreboard bench for n64_poll_scheduler with a scripted engine model.
module tb_n64_poll_scheduler;

   localparam int unsigned POLL_P  = 100;
   localparam int unsigned TMO     = 20;
   localparam int unsigned RETRIES = 2;
   localparam int unsigned GAP     = 4;

   localparam logic [1:0] R_OK  = 2'd0;
   localparam logic [1:0] R_ERR = 2'd1;
   localparam logic [1:0] R_SIL = 2'd2;

   localparam logic [7:0] C_INFO  = 8'h00;
   localparam logic [7:0] C_POLL  = 8'h01;
   localparam logic [7:0] C_RESET = 8'hFF;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] data;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        poll_enable = 1'b0;
   logic        reset_req = 1'b0;
   logic        info_req = 1'b0;
   logic        engine_active = 1'b0;
   logic        rx_done, rx_error;
   logic [31:0] rx_data;
   logic        cmd_start, button_valid, status_valid, busy;
   logic [7:0]  cmd_byte, err_count;
   logic [31:0] button_data;
   logic [23:0] status_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   resp_t       resp_q[$];
   logic [7:0]  exp_cmd_q[$];
   logic [31:0] exp_btn_q[$];
   logic [23:0] exp_sts_q[$];
   int          cmd_cyc_q[$];
   logic [31:0] mdl_btn  = '0;
   bit          mdl_have = 1'b0;
   resp_t       eng_r;

   n64_poll_scheduler #(
      .POLL_PERIOD    (POLL_P),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRIES    (RETRIES),
      .GAP_CYCLES     (GAP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .poll_enable   (poll_enable),
      .reset_req     (reset_req),
      .info_req      (info_req),
      .cmd_start     (cmd_start),
      .cmd_byte      (cmd_byte),
      .engine_active (engine_active),
      .rx_done       (rx_done),
      .rx_error      (rx_error),
      .rx_data       (rx_data),
      .button_data   (button_data),
      .button_valid  (button_valid),
      .status_data   (status_data),
      .status_valid  (status_valid),
      .err_count     (err_count),
      .busy          (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Button model: with change-only enabled, repeats of the last value are silent
   task automatic model_btn(input logic [31:0] d);
`ifdef N64_SCHED_CHANGE_ONLY_EN
      if (!mdl_have || d != mdl_btn) exp_btn_q.push_back(d);
`else
      exp_btn_q.push_back(d);
`endif
      mdl_btn  = d;
      mdl_have = 1'b1;
   endtask

   task automatic push_txn(input logic [7:0] cmd, input logic [1:0] kind, input logic [31:0] d);
      resp_t r;
      r.kind = kind;
      r.data = d;
      exp_cmd_q.push_back(cmd);
      resp_q.push_back(r);
      if (kind == R_OK) begin
         if (cmd == C_POLL) model_btn(d);
         else               exp_sts_q.push_back(d[23:0]);
      end
   endtask

   task automatic drain(input string tag);
      check({tag, "_cmd_left"}, 32'(exp_cmd_q.size()), 32'd0);
      check({tag, "_btn_left"}, 32'(exp_btn_q.size()), 32'd0);
      check({tag, "_sts_left"}, 32'(exp_sts_q.size()), 32'd0);
      exp_cmd_q.delete();
      exp_btn_q.delete();
      exp_sts_q.delete();
      resp_q.delete();
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      repeat (2) @(negedge clk);
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle_reached", 32'(busy), 32'd0);
   endtask

   task automatic poll_window(input int n);
      poll_enable = 1'b1;
      cycles(n);
      poll_enable = 1'b0;
   endtask

   // Engine model: answers each cmd_start with the next scripted response
   initial begin
      rx_done  = 1'b0;
      rx_error = 1'b0;
      rx_data  = '0;
      forever begin
         @(negedge clk);
         if (cmd_start && resp_q.size() > 0) begin
            eng_r = resp_q.pop_front();
            if (eng_r.kind != R_SIL) begin
               repeat (4) @(negedge clk);
               rx_done  = 1'b1;
               rx_error = (eng_r.kind == R_ERR);
               rx_data  = eng_r.data;
               @(negedge clk);
               rx_done  = 1'b0;
               rx_error = 1'b0;
               rx_data  = '0;
            end
         end
      end
   end

   // Output monitor: every DUT event pops and compares a scoreboard entry
   initial begin
      forever begin
         @(negedge clk);
         if (cmd_start) begin
            cmd_cyc_q.push_back(cyc);
            check("cmd_expected", 32'(exp_cmd_q.size() > 0), 32'd1);
            if (exp_cmd_q.size() > 0) check("cmd_byte", 32'(cmd_byte), 32'(exp_cmd_q.pop_front()));
         end
         if (button_valid) begin
            check("btn_expected", 32'(exp_btn_q.size() > 0), 32'd1);
            if (exp_btn_q.size() > 0) check("button_data", button_data, exp_btn_q.pop_front());
         end
         if (status_valid) begin
            check("sts_expected", 32'(exp_sts_q.size() > 0), 32'd1);
            if (exp_sts_q.size() > 0) check("status_data", 32'(status_data), 32'(exp_sts_q.pop_front()));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int exp_err;

      // Reset state
      cycles(3);
      #1;
      check("rst_cmd_start", 32'(cmd_start), 32'd0);
      check("rst_cmd_byte", 32'(cmd_byte), 32'd0);
      check("rst_button_data", button_data, 32'd0);
      check("rst_button_valid", 32'(button_valid), 32'd0);
      check("rst_status_data", 32'(status_data), 32'd0);
      check("rst_status_valid", 32'(status_valid), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Priority: all three requests pending together while the engine is busy
      engine_active = 1'b1;
      reset_req     = 1'b1;
      info_req      = 1'b1;
      poll_enable   = 1'b1;
      cycles(1);
      info_req = 1'b0;
      cycles(110);
      check("prio_held_by_engine", 32'(busy), 32'd0);
      push_txn(C_RESET, R_OK, 32'h00AB_CDEF);
      push_txn(C_INFO,  R_OK, 32'h1122_3344);
      push_txn(C_POLL,  R_OK, 32'hCAFE_0001);
      cmd_cyc_q.delete();
      engine_active = 1'b0;
      cycles(50);
      poll_enable = 1'b0;
      reset_req   = 1'b0;
      check("prio_cmd_count", 32'(cmd_cyc_q.size()), 32'd3);
      for (int i = 1; i < cmd_cyc_q.size(); i++)
         check("prio_spacing", 32'((cmd_cyc_q[i] - cmd_cyc_q[i-1]) >= int'(GAP + 2)), 32'd1);
      check("prio_status", 32'(status_data), 32'h0022_3344);
      drain("prio");

      // Periodic poll: one transaction per period
      cmd_cyc_q.delete();
      for (int i = 0; i < 3; i++) push_txn(C_POLL, R_OK, 32'h8000_1234);
      poll_window(300);
      cycles(40);
      check("per_cmd_count", 32'(cmd_cyc_q.size()), 32'd3);
      for (int i = 1; i < cmd_cyc_q.size(); i++)
         check("per_period", 32'(cmd_cyc_q[i] - cmd_cyc_q[i-1]), POLL_P);
      check("per_button", button_data, 32'h8000_1234);
      drain("per");

      // Two errors, then success on the final allowed retry
      cmd_cyc_q.delete();
      push_txn(C_POLL, R_ERR, 32'hDEAD_BEEF);
      push_txn(C_POLL, R_ERR, 32'hDEAD_BEEF);
      push_txn(C_POLL, R_OK,  32'h0000_00A5);
      poll_window(100);
      cycles(100);
      check("retry_cmd_count", 32'(cmd_cyc_q.size()), 32'd3);
      check("retry_err_count", 32'(err_count), 32'd0);
      check("retry_button", button_data, 32'h0000_00A5);
      drain("retry");

      // Timeout exhaustion: silent engine, three attempts then a drop
      cmd_cyc_q.delete();
      for (int i = 0; i < 3; i++) push_txn(C_POLL, R_SIL, 32'h0);
      poll_window(100);
      cycles(120);
      check("tmo_cmd_count", 32'(cmd_cyc_q.size()), 32'd3);
      for (int i = 1; i < cmd_cyc_q.size(); i++)
         check("tmo_spacing", 32'(cmd_cyc_q[i] - cmd_cyc_q[i-1]), 1 + TMO + GAP);
      check("tmo_err_count", 32'(err_count), 32'd1);
      check("tmo_button", button_data, 32'h0000_00A5);
      drain("tmo");

      // Error counter saturation using info requests
      exp_err = 1;
      for (int i = 0; i < 260; i++) begin
         for (int j = 0; j < 3; j++) push_txn(C_INFO, R_SIL, 32'h0);
         info_req = 1'b1;
         cycles(1);
         info_req = 1'b0;
         wait_idle(200);
         exp_err = (exp_err < 255) ? exp_err + 1 : 255;
         check("sat_err_count", 32'(err_count), 32'(exp_err));
      end
      drain("sat");

      // Async reset in WAIT; the late response must be ignored
      exp_cmd_q.push_back(C_INFO);
      begin
         resp_t r;
         r.kind = R_OK;
         r.data = 32'h0077_7777;
         resp_q.push_back(r);
      end
      info_req = 1'b1;
      cycles(1);
      info_req = 1'b0;
      k = 0;
      while (!cmd_start && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("arst_cmd_seen", 32'(cmd_start), 32'd1);
      cycles(2);
      #1 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_cmd_byte", 32'(cmd_byte), 32'd0);
      check("arst_err_count", 32'(err_count), 32'd0);
      check("arst_button", button_data, 32'd0);
      check("arst_status", 32'(status_data), 32'd0);
      check("arst_cmd_start", 32'(cmd_start), 32'd0);
      mdl_have = 1'b0;
      mdl_btn  = '0;
      @(negedge clk);
      rst = 1'b0;
      cycles(10);
      check("late_status", 32'(status_data), 32'd0);
      check("late_busy", 32'(busy), 32'd0);
      drain("arst");

      // Two identical polls (change-only build pulses once)
      cmd_cyc_q.delete();
      push_txn(C_POLL, R_OK, 32'h0000_0001);
      push_txn(C_POLL, R_OK, 32'h0000_0001);
      poll_window(200);
      cycles(40);
      check("dup_cmd_count", 32'(cmd_cyc_q.size()), 32'd2);
      check("dup_button", button_data, 32'h0000_0001);
      drain("dup");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/n64_poll_scheduler.md
Name: n64_poll_scheduler

Overview:
- Sequences the shared N64 single-wire transaction engine: the write-command and read-response pair plus the open-collector pad.
- Arbitrates three requesters for the engine: controller reset, status/info query, and the periodic button poll.
- Adds timeout, bounded retry and inter-transaction gap.
- Publishes button data atomically and status data, each with a valid pulse.
- Sits between the top-level CPU/config glue and the transaction engine.

Parameters:
POLL_PERIOD, 100000, clk cycles between poll ticks (1 ms at 100 MHz); >=2
TIMEOUT_CYCLES, 20000, max cycles in WAIT before a transaction counts as failed; >=2
MAX_RETRIES, 2, re-issues after the first failure before a transaction is dropped; 0..7
GAP_CYCLES, 200, mandatory idle cycles after every transaction, successful or failed; >=1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
poll_enable  in  1  level; enables periodic button polling
reset_req  in  1  level; each rising edge queues one controller-reset command
info_req  in  1  single-cycle pulse; queues one info command
cmd_start  out  1  one-cycle pulse to the engine: begin a transaction
cmd_byte  out  8  command to send; stable from cmd_start until the transaction ends
engine_active  in  1  engine busy flag (informational; also gates ISSUE)
rx_done  in  1  one-cycle pulse: response capture finished
rx_error  in  1  qualifies rx_done: response malformed
rx_data  in  32  response bits; valid with rx_done
button_data  out  32  last good poll response
button_valid  out  1  one-cycle pulse when button_data updates
status_data  out  24  last good info/reset response, rx_data[23:0]
status_valid  out  1  one-cycle pulse when status_data updates
err_count  out  8  count of dropped transactions; saturates at 255
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; all pending flags, counters and edge-detect register 0.
- Async rst asserted mid-transaction aborts immediately; engine completion pulses that arrive later land in IDLE and are ignored.
- Poll timer:
  - Free-running counter 0..POLL_PERIOD-1; tick when the counter equals POLL_PERIOD-1.
  - Tick with poll_enable=1 sets poll_pend.
  - A tick while poll_pend is already set coalesces: no extra request.
  - poll_enable=0 clears poll_pend; an in-flight poll still completes.
- reset_pend is set on a reset_req rising edge (registered edge detect). info_pend is set on info_req=1. A set and a clear-by-grant of the same flag in one cycle leave the flag set.
- Priority when granting: reset (cmd 0xFF) > info (0x00) > poll (0x01). A grant clears the matching pend flag.
- States:
  - IDLE: if any pend and engine_active=0, grant, latch cmd_byte, retry_cnt=0, go to ISSUE.
  - ISSUE: cmd_start=1 for exactly this cycle; clear timeout counter; go to WAIT. cmd_start is therefore asserted 1 cycle after the grant.
  - WAIT: count cycles.
    - rx_done=1 and rx_error=0 means success:
      - poll: button_data<=rx_data; button_valid=1 next cycle.
      - info/reset: status_data<=rx_data[23:0]; status_valid=1 next cycle.
      - Then go to GAP.
    - rx_done with rx_error=1, or counter reaches TIMEOUT_CYCLES-1, means failure:
      - If retry_cnt<MAX_RETRIES: retry_cnt++, go to GAP, then reissue the same cmd_byte without re-arbitration.
      - Otherwise drop the transaction: err_count++ (saturating), outputs unchanged, go to GAP.
    - rx_done and timeout in the same cycle: rx_done wins.
  - GAP: count GAP_CYCLES, then go to IDLE, or to ISSUE if a retry is outstanding.
- rx_done outside WAIT is ignored.
- button_data and status_data change only on success (atomic 32-bit update); never partial.

Optional Feature:
N64_SCHED_CHANGE_ONLY_EN
- Defined: on poll success, button_data is still updated, but button_valid pulses only if rx_data differs from the previous button_data. The first success after reset always pulses.
- Undefined: button_valid pulses on every successful poll.

Decomposition:
- Shared package n64_pkg:
  - CMD_INFO=8'h00, CMD_POLL=8'h01, CMD_RESET=8'hFF
  - scheduler state encoding IDLE/ISSUE/WAIT/GAP
  - requester index constants
- One natural sub-module: n64_poll_tick. It holds the POLL_PERIOD counter and emits the tick pulse, and is reusable by other periodic controller tasks.

Test Plan:
All scenarios use POLL_PERIOD=100, TIMEOUT_CYCLES=20, MAX_RETRIES=2, GAP_CYCLES=4.
- Periodic poll: poll_enable=1, engine model returns rx_done with rx_data=32'h8000_1234 five cycles after cmd_start -> cmd_byte=0x01 and a single cmd_start per 100-cycle tick; button_data=32'h8000_1234; button_valid pulses once per period.
- Priority: reset_req rising edge, info_req pulse and poll tick all in the same cycle -> transactions issue in order 0xFF, 0x00, 0x01, each separated by >=4 GAP cycles.
- Retry then success: first two responses carry rx_error=1, third returns 32'h0000_00A5 -> three cmd_starts with 0x01; err_count=0; button_data=32'h0000_00A5.
- Timeout exhaustion: engine never asserts rx_done -> 3 cmd_starts each 20 cycles apart plus gaps; err_count=1; button_data unchanged; no button_valid.
- Saturation and async reset: 260 forced drops -> err_count=255. Then assert rst mid-WAIT -> all outputs 0 immediately; a late rx_done is ignored.
- With N64_SCHED_CHANGE_ONLY_EN: two identical successes with 32'h1 -> exactly one button_valid pulse.
